// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryptor: ROUNDS_PER_CYCLE rounds per clock, round keys expanded on the fly.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds its data stable until then.
module aes128_iter_encrypt #(
  parameter int N                = 128,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] plaintext,
  input  logic [N-1:0] secret_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ciphertext,
  output logic         busy
);

  if (N != 128) begin : g_bad_width
    $error("aes128_iter_encrypt: N must be 128");
  end
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes128_iter_encrypt: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state, state_next;
  logic [127:0]   state_reg, rkey_reg;
  logic [7:0]     rcon;
  logic [3:0]     cnt, cnt_next;
  logic           last_step;
  logic [127:0]   s_chain, k_chain;
  logic [7:0]     rc_chain;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = sr[127-32*c -: 32];
      if (last) mc[127-32*c -: 32] = {a0, a1, a2, a3};
      else mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return mc ^ k;
  endfunction

  always_comb begin
    s_chain  = state_reg;
    k_chain  = rkey_reg;
    rc_chain = rcon;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      k_chain  = next_key(k_chain, rc_chain);
      rc_chain = xtime(rc_chain);
      s_chain  = aes_round(s_chain, k_chain, (int'(cnt) + i) == 9);
    end
  end

  assign cnt_next  = cnt + 4'(ROUNDS_PER_CYCLE);
  assign last_step = (cnt_next == 4'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) state_next = IDLE;
    else begin
      unique case (state)
        IDLE:    if (in_valid)  state_next = RUN;
        RUN:     if (last_step) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  // clear discards work in flight but leaves the last ciphertext visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= '0;
      rkey_reg   <= '0;
      rcon       <= 8'h01;
      cnt        <= '0;
      ciphertext <= '0;
    end else if (!clear) begin
      if (state == IDLE && in_valid) begin
        state_reg <= plaintext ^ secret_key;
        rkey_reg  <= secret_key;
        rcon      <= 8'h01;
        cnt       <= '0;
      end else if (state == RUN) begin
        state_reg <= s_chain;
        rkey_reg  <= k_chain;
        rcon      <= rc_chain;
        cnt       <= cnt_next;
        if (last_step) ciphertext <= s_chain;
      end
    end
  end

endmodule

// File: doc/aes128_iter_encrypt.md
Name: aes128_iter_encrypt

Overview:
Parametrised AES-128 encryption core with an iterative, handshaked datapath. It is the sequential successor to the fully unrolled encryption pipeline. It processes ROUNDS_PER_CYCLE rounds per clock and expands round keys on the fly rather than precomputing all eleven. It sits between the plaintext/key source and the ciphertext sink, using valid/ready on both sides.

Parameters:
N, 128, block and key width in bits; fixed at 128, any other value is an elaboration error.
ROUNDS_PER_CYCLE, 1, AES rounds applied per clock; legal values are 1, 2, 5 and 10, anything else is an elaboration error.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort; returns the core to IDLE.
in_valid  input  1  plaintext/key pair presented.
in_ready  output  1  core can accept a new pair.
plaintext  input  N  input block; bits [127:120] are byte 0 (FIPS-197 order).
secret_key  input  N  cipher key, same byte order.
out_valid  output  1  ciphertext valid.
out_ready  input  1  sink accepts ciphertext.
ciphertext  output  N  result block.
busy  output  1  high in RUN state.

Behaviour:
- Reset (rst_n=0, asynchronous), applies at any time including mid-operation:
  - state goes to IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - ciphertext, state register, round-key register and round counter all go to 0.
  - rcon register goes to 0x01.
- States and transitions:
  - IDLE -> RUN on in_valid && in_ready.
  - RUN -> DONE when the round counter reaches 10.
  - DONE -> IDLE on out_ready.
- in_ready=1 only in IDLE. in_valid in any other state is ignored, and inputs are not sampled.
- Accept edge (IDLE, in_valid=1):
  - state_reg <= plaintext ^ secret_key.
  - rkey_reg <= secret_key.
  - rcon <= 0x01.
  - round counter <= 0.
- RUN, per clock, ROUNDS_PER_CYCLE rounds are chained combinationally. For each round r:
  - The next round key is derived from the current one: RotWord, SubWord, XOR with rcon, then the standard 4-word chain.
  - rcon advances by xtime: 0x01, 0x02, …, 0x80, 0x1b, 0x36.
  - The round applies SubBytes, ShiftRows, MixColumns and AddRoundKey.
  - Round 10 omits MixColumns.
  - After the clock, counter += ROUNDS_PER_CYCLE.
- Leaving RUN:
  - The edge on which the counter reaches 10 writes the final state into ciphertext and enters DONE.
  - out_valid=1 from the following cycle.
- Latency: an accept on edge k gives out_valid high after edge k + 10/ROUNDS_PER_CYCLE.
  - ROUNDS_PER_CYCLE=1: 10 cycles.
  - ROUNDS_PER_CYCLE=10: 1 cycle.
- DONE:
  - ciphertext and out_valid are held stable until out_ready=1.
  - The transfer completes on the edge with out_valid && out_ready. out_valid then drops and the state is IDLE.
  - A new input is accepted at the earliest on the cycle after.
- Throughput: one block per 10/ROUNDS_PER_CYCLE + 2 cycles when out_ready is held high.
- clear=1 on a clock edge, in any state:
  - Next state is IDLE and out_valid=0.
  - Any result in flight or held in DONE is discarded.
  - ciphertext retains its last value.
  - clear has priority over accept and over the out handshake on the same edge.
- Simultaneous in_valid=1 and clear=1 in IDLE: no accept.
- plaintext and secret_key may change after the accept edge without affecting the result.
- ciphertext is registered, with no combinational path from inputs to outputs. in_ready, out_valid and busy are decoded from state only.
- Key storage holds a single 128-bit round key. No precomputed key array is kept.

Test Plan:
1. FIPS-197 C.1, ROUNDS_PER_CYCLE=1:
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1.
   - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept, high for 1 cycle.
2. FIPS-197 Appendix B, repeated for ROUNDS_PER_CYCLE 1, 2, 5 and 10:
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Required: ciphertext 3925841d02dc09fbdc118597196a0b32; latency 10, 5, 2 and 1 cycles respectively.
3. Backpressure:
   - Stimulus: out_ready=0 for 20 cycles after out_valid rises; in_valid held high throughout with a different pt.
   - Required: ciphertext stable, in_ready=0, second block not accepted until the cycle after out_ready is raised; second result then correct.
4. Back-to-back throughput:
   - Stimulus: 4 blocks with in_valid and out_ready always 1, ROUNDS_PER_CYCLE=2.
   - Required: one result every 7 cycles, each matching the software model.
5. Abort:
   - Stimulus: clear pulsed at round 4 (ROUNDS_PER_CYCLE=1).
   - Required: next cycle IDLE, in_ready=1, no out_valid; the following block encrypts correctly.
6. Reset:
   - Stimulus: rst_n asserted mid-RUN, off the clock edge.
   - Required: outputs go to reset values immediately, without waiting for a clock; after release, vector 1 passes.
